core_if_stage: RTL and testbench

Instruction fetch stage of the core. It owns the program counter and issues in-order word fetches to instruction memory over a request/grant bus. Returned words go into a small fetch buffer. It presents `{pc, instruction}` pairs to `core_id_stage` through a valid/ready handshake, and restarts fetch at a new PC on a redirect from the jump/branch logic, discarding stale fetches.

---
 rtl/core_pkg.sv | 21 ++
 rtl/core_fetch_fifo.sv | 71 +++++++
 rtl/core_if_stage.sv | 119 +++++++++++
 tb/tb_core_if_stage.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the core pipeline stages.
package core_pkg;

    // Bytes per instruction word; the fetch PC advances by this amount.
    localparam int INSTR_BYTES = 4;

    // Canonical no-op (addi x0, x0, 0) used downstream to insert bubbles.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Force an address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/core_fetch_fifo.sv
// Small circular buffer of fetched instructions. The head entry is read
// straight out of storage registers, so the consumer sees registered data.
module core_fetch_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    output logic [CW-1:0] count_o,
    output logic          head_valid_o,
    output fetch_entry_t  head_o
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop       = pop_i && (count_q != '0);
    assign count_o      = count_q;
    assign head_valid_o = (count_q != '0);
    assign head_o       = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy; flush wins over any push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push_i && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (!push_i && do_pop) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // The producer's credit scheme must never overfill the buffer.
    assert property (@(posedge clk) disable iff (rst)
        !(push_i && !flush_i && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/core_if_stage.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches on a
// request/grant bus, buffers returned words and hands {pc, instr} to ID.
//
// Handshake to ID: an instruction transfers on a rising edge where
// o_instr_valid and i_instr_ready are both high. While valid is high and
// ready is low, o_instr/o_instr_pc hold. Valid never depends on ready.
module core_if_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc
);

    localparam int            CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   pc_req_q, pc_req_d;
    logic [31:0]   pc_rsp_q, pc_rsp_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;

    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;
    logic [31:0]   redirect_pc;
    logic          pop;
    logic          grant;
    logic          rsp_valid;
    logic          push;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    assign redirect_pc = word_align(i_redirect_pc);
    assign pop         = o_instr_valid & i_instr_ready;

    // A response with nothing outstanding is a leftover from before reset.
    assign rsp_valid   = i_imem_rvalid && (outstanding_q != '0);

    // In-flight requests plus buffered words may never exceed the buffer
    // depth, so every response is guaranteed a free slot on arrival.
    assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count}
                       - {{CW{1'b0}}, pop};
    assign o_imem_req  = !rst && !i_redirect && (credit_used < DEPTH_C);
    assign o_imem_addr = pc_req_q;
    assign grant       = o_imem_req && i_imem_gnt;

    assign push        = rsp_valid && !i_redirect && (discard_q == '0);
    assign push_entry  = '{pc: pc_rsp_q, instr: i_imem_rdata};

    // Next-state for PCs and counters; a redirect overrides grants and pushes.
    always_comb begin
        pc_req_d      = pc_req_q;
        pc_rsp_d      = pc_rsp_q;
        outstanding_d = outstanding_q + CW'(grant) - CW'(rsp_valid);
        discard_d     = discard_q;
        if (i_redirect) begin
            pc_req_d  = redirect_pc;
            pc_rsp_d  = redirect_pc;
            discard_d = outstanding_q - CW'(rsp_valid);
        end else begin
            if (grant) begin
                pc_req_d = pc_req_q + 32'(INSTR_BYTES);
            end
            if (rsp_valid) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CW'(1);
                end else begin
                    pc_rsp_d = pc_rsp_q + 32'(INSTR_BYTES);
                end
            end
        end
    end

    // PC and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_req_q      <= RESET_PC;
            pc_rsp_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            pc_req_q      <= pc_req_d;
            pc_rsp_q      <= pc_rsp_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    core_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (i_redirect),
        .push_i       (push),
        .push_data_i  (push_entry),
        .pop_i        (pop),
        .count_o      (fifo_count),
        .head_valid_o (o_instr_valid),
        .head_o       (head)
    );

    assign o_instr    = head.instr;
    assign o_instr_pc = head.pc;

endmodule

// File: tb/tb_core_if_stage.sv
// Bench for core_if_stage with RESET_PC=0x100 and a two-entry fetch buffer.
module tb_core_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt = 1'b0;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = '0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_instr_valid;
    logic        i_instr_ready = 1'b0;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pops     = 0;

    // memory behaviour knobs
    int gnt_mode  = 1;   // 0 never, 1 always, 2 random
    int lat_fixed = 1;
    bit lat_rand  = 1'b0;
    bit rv_rand   = 1'b0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_ent_t;

    mem_ent_t    mem_q[$];
    logic [63:0] exp_q[$];
    int          buf_cnt    = 0;
    int          stale_cnt  = 0;
    logic [31:0] exp_req_pc = RST_PC;
    bit          prev_hold  = 1'b0;
    logic [63:0] prev_head  = '0;

    core_if_stage #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_instr_valid (o_instr_valid),
        .i_instr_ready (i_instr_ready),
        .o_instr       (o_instr),
        .o_instr_pc    (o_instr_pc)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_1E0F;
    endfunction

    // Memory model: grant per mode, in-order responses once their due cycle arrives.
    always @(negedge clk) begin
        case (gnt_mode)
            0:       i_imem_gnt = 1'b0;
            1:       i_imem_gnt = 1'b1;
            default: i_imem_gnt = ($urandom_range(0, 2) != 0);
        endcase
        if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc &&
            (!rv_rand || $urandom_range(0, 3) != 0)) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = mem_word(mem_q[0].addr);
        end else begin
            i_imem_rvalid = 1'b0;
            i_imem_rdata  = $urandom;
        end
    end

    // Scoreboard: every word granted since the last redirect must reach ID
    // in order; anything granted earlier must vanish.
    always begin
        int          used;
        bit          exp_req;
        logic [63:0] exp_e;
        @(negedge clk);
        #3;
        if (rst) begin
            mem_q.delete();
            exp_q.delete();
            buf_cnt    = 0;
            stale_cnt  = 0;
            exp_req_pc = RST_PC;
            prev_hold  = 1'b0;
        end else begin
            if (prev_hold) begin
                checks++;
                if ({o_instr_pc, o_instr} !== prev_head) begin
                    failures++;
                    $display("FAIL mon_hold got=%h exp=%h", {o_instr_pc, o_instr}, prev_head);
                end
            end
            checks++;
            if (o_instr_valid !== (buf_cnt != 0)) begin
                failures++;
                $display("FAIL mon_valid got=%b exp=%b", o_instr_valid, (buf_cnt != 0));
            end
            used    = mem_q.size() + buf_cnt - ((o_instr_valid && i_instr_ready) ? 1 : 0);
            exp_req = !i_redirect && (used < DEPTH);
            checks++;
            if (o_imem_req !== exp_req) begin
                failures++;
                $display("FAIL mon_req got=%b exp=%b", o_imem_req, exp_req);
            end
            if (o_imem_req && exp_req) begin
                checks++;
                if (o_imem_addr !== exp_req_pc) begin
                    failures++;
                    $display("FAIL mon_addr got=%h exp=%h", o_imem_addr, exp_req_pc);
                end
            end
            if (i_imem_rvalid && mem_q.size() > 0) begin
                void'(mem_q.pop_front());
                if (stale_cnt > 0) stale_cnt--;
                else if (!i_redirect) buf_cnt++;
            end
            if (o_instr_valid && i_instr_ready && !i_redirect) begin
                pops++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL mon_pop got_pc=%h exp=none", o_instr_pc);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({o_instr_pc, o_instr} !== exp_e) begin
                        failures++;
                        $display("FAIL mon_pop got=%h exp=%h", {o_instr_pc, o_instr}, exp_e);
                    end
                end
                if (buf_cnt > 0) buf_cnt--;
            end
            if (o_imem_req && i_imem_gnt) begin
                mem_q.push_back('{addr: o_imem_addr,
                                  due: cyc + (lat_rand ? int'($urandom_range(1, 3)) : lat_fixed)});
                exp_q.push_back({exp_req_pc, mem_word(exp_req_pc)});
                exp_req_pc = exp_req_pc + 32'd4;
            end
            if (i_redirect) begin
                stale_cnt  = mem_q.size();
                buf_cnt    = 0;
                exp_q.delete();
                exp_req_pc = {i_redirect_pc[31:2], 2'b00};
            end
            prev_hold = o_instr_valid && !i_instr_ready && !i_redirect;
            prev_head = {o_instr_pc, o_instr};
        end
    end

    // Driver: hold reset with the requested memory/ready setup; returns on a negedge.
    task automatic apply_reset(input int gm, input int lat, input bit ready);
        @(negedge clk);
        #1;
        rst           = 1'b1;
        i_redirect    = 1'b0;
        gnt_mode      = gm;
        lat_fixed     = lat;
        lat_rand      = 1'b0;
        rv_rand       = 1'b0;
        i_instr_ready = ready;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset(1, 1, 1'b1);
        #3;
        checks++; if (o_imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", o_imem_req); end
        checks++; if (o_imem_addr !== RST_PC) begin failures++; $display("FAIL rst_addr got=%h exp=%h", o_imem_addr, RST_PC); end
        checks++; if (o_instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", o_instr_valid); end
        checks++; if (o_instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", o_instr); end
        checks++; if (o_instr_pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", o_instr_pc); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] p;
        apply_reset(1, 1, 1'b1);
        rst = 1'b0;
        #3;
        checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== RST_PC) begin
            failures++; $display("FAIL zw_first_req got=%b/%h exp=1/%h", o_imem_req, o_imem_addr, RST_PC); end
        @(negedge clk); #3;
        checks++; if (o_instr_valid !== 1'b0) begin failures++; $display("FAIL zw_early_valid got=%b exp=0", o_instr_valid); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #3;
            p = RST_PC + 32'(4 * k);
            checks++;
            if (o_instr_valid !== 1'b1 || o_instr_pc !== p || o_instr !== mem_word(p)) begin
                failures++;
                $display("FAIL zw_stream got=%b/%h/%h exp=1/%h/%h", o_instr_valid, o_instr_pc, o_instr, p, mem_word(p));
            end
        end
    endtask

    task automatic test_gnt_stall();
        apply_reset(0, 1, 1'b1);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #3;
            checks++;
            if (o_imem_req !== 1'b1 || o_imem_addr !== RST_PC) begin
                failures++; $display("FAIL gnt_hold got=%b/%h exp=1/%h", o_imem_req, o_imem_addr, RST_PC);
            end
        end
        gnt_mode = 1;
        @(negedge clk); #3;
        checks++; if (o_imem_addr !== RST_PC) begin failures++; $display("FAIL gnt_first got=%h exp=%h", o_imem_addr, RST_PC); end
        @(negedge clk); #3;
        checks++; if (o_imem_addr !== RST_PC + 32'd4) begin failures++; $display("FAIL gnt_next got=%h exp=%h", o_imem_addr, RST_PC + 32'd4); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_ready_stall();
        apply_reset(1, 1, 1'b0);
        rst = 1'b0;
        #3;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #3;
            checks++;
            if (o_imem_req !== 1'b0 || o_instr_valid !== 1'b1 || o_instr_pc !== RST_PC || o_instr !== mem_word(RST_PC)) begin
                failures++;
                $display("FAIL stall_hold got=%b/%b/%h exp=0/1/%h", o_imem_req, o_instr_valid, o_instr_pc, RST_PC);
            end
        end
        @(negedge clk); i_instr_ready = 1'b1; #3;
        checks++; if (o_instr_pc !== RST_PC) begin failures++; $display("FAIL stall_rel0 got=%h exp=%h", o_instr_pc, RST_PC); end
        @(negedge clk); #3;
        checks++; if (o_instr_pc !== RST_PC + 32'd4) begin failures++; $display("FAIL stall_rel1 got=%h exp=%h", o_instr_pc, RST_PC + 32'd4); end
        @(negedge clk); #3;
        checks++; if (o_instr_valid !== 1'b1 || o_instr_pc !== RST_PC + 32'd8) begin
            failures++; $display("FAIL stall_rel2 got=%b/%h exp=1/%h", o_instr_valid, o_instr_pc, RST_PC + 32'd8); end
    endtask

    task automatic test_redirect();
        bit seen;
        apply_reset(1, 3, 1'b1);
        rst = 1'b0;
        #3;
        @(negedge clk);
        @(negedge clk);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_2003;
        #3;
        checks++; if (o_imem_req !== 1'b0) begin failures++; $display("FAIL redir_req got=%b exp=0", o_imem_req); end
        @(negedge clk);
        i_redirect = 1'b0;
        #3;
        checks++; if (o_instr_valid !== 1'b0) begin failures++; $display("FAIL redir_flush got=%b exp=0", o_instr_valid); end
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk); #3;
            seen = o_instr_valid;
        end
        checks++;
        if (!seen) begin
            failures++; $display("FAIL redir_timeout got=none exp=%h", 32'h2000);
        end else if (o_instr_pc !== 32'h0000_2000 || o_instr !== mem_word(32'h2000)) begin
            failures++; $display("FAIL redir_first got=%h/%h exp=%h/%h", o_instr_pc, o_instr, 32'h2000, mem_word(32'h2000));
        end
    endtask

    task automatic test_redirect_rvalid_pop();
        apply_reset(1, 1, 1'b1);
        rst = 1'b0;
        #3;
        repeat (5) @(negedge clk);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_3000;
        #3;
        checks++; if (o_instr_valid !== 1'b1) begin failures++; $display("FAIL rvp_steady got=%b exp=1", o_instr_valid); end
        @(negedge clk);
        i_redirect = 1'b0;
        #3;
        checks++; if (o_instr_valid !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h3000) begin
            failures++; $display("FAIL rvp_restart got=%b/%b/%h exp=0/1/%h", o_instr_valid, o_imem_req, o_imem_addr, 32'h3000); end
        @(negedge clk); #3;
        checks++; if (o_instr_valid !== 1'b0) begin failures++; $display("FAIL rvp_gap got=%b exp=0", o_instr_valid); end
        @(negedge clk); #3;
        checks++; if (o_instr_valid !== 1'b1 || o_instr_pc !== 32'h3000 || o_instr !== mem_word(32'h3000)) begin
            failures++; $display("FAIL rvp_first got=%b/%h exp=1/%h", o_instr_valid, o_instr_pc, 32'h3000); end
    endtask

    task automatic test_reset_mid();
        apply_reset(1, 1, 1'b0);
        rst = 1'b0;
        #3;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++; if (o_imem_req !== 1'b0 || o_imem_addr !== RST_PC) begin
            failures++; $display("FAIL rmid_req got=%b/%h exp=0/%h", o_imem_req, o_imem_addr, RST_PC); end
        checks++; if (o_instr_valid !== 1'b0 || o_instr !== 32'h0 || o_instr_pc !== 32'h0) begin
            failures++; $display("FAIL rmid_out got=%b/%h/%h exp=0/0/0", o_instr_valid, o_instr, o_instr_pc); end
        repeat (2) @(negedge clk);
        rst           = 1'b0;
        i_instr_ready = 1'b1;
        #3;
        checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== RST_PC) begin
            failures++; $display("FAIL rmid_restart got=%b/%h exp=1/%h", o_imem_req, o_imem_addr, RST_PC); end
        repeat (2) @(negedge clk);
        #3;
        checks++; if (o_instr_valid !== 1'b1 || o_instr_pc !== RST_PC) begin
            failures++; $display("FAIL rmid_first got=%b/%h exp=1/%h", o_instr_valid, o_instr_pc, RST_PC); end
    endtask

    task automatic test_wrap();
        logic [31:0] p;
        apply_reset(1, 1, 1'b1);
        rst = 1'b0;
        #3;
        repeat (3) @(negedge clk);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'hFFFF_FFFE;
        @(negedge clk);
        i_redirect = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #3;
            p = 32'hFFFF_FFFC + 32'(4 * k);
            checks++;
            if (o_instr_valid !== 1'b1 || o_instr_pc !== p || o_instr !== mem_word(p)) begin
                failures++; $display("FAIL wrap got=%b/%h exp=1/%h", o_instr_valid, o_instr_pc, p);
            end
        end
    endtask

    task automatic test_random();
        int start_pops;
        apply_reset(2, 1, 1'b1);
        lat_rand = 1'b1;
        rv_rand  = 1'b1;
        rst      = 1'b0;
        start_pops = pops;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            i_instr_ready = ($urandom_range(0, 3) != 0);
            if (i_redirect) begin
                i_redirect = 1'b0;
            end else if ($urandom_range(0, 39) == 0) begin
                i_redirect    = 1'b1;
                i_redirect_pc = $urandom;
            end
        end
        @(negedge clk);
        i_redirect = 1'b0;
        #3;
        checks++;
        if (pops - start_pops < 200) begin
            failures++; $display("FAIL rand_progress got=%0d exp>=200", pops - start_pops);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_gnt_stall();
        test_ready_stall();
        test_redirect();
        test_redirect_rvalid_pop();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
